// File: rtl/stream_min_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_min_tracker_pkg                                    |
// | Brief    : Shared types and helpers for the streaming min tracker.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package stream_min_tracker_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic c_sel_min = 1'b0;
    localparam logic c_sel_max = 1'b1;

    // Largest number of samples a frame may hold before it is force-closed.
    function automatic int unsigned frame_limit(input int unsigned idx_w);
        return 32'd1 << idx_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_min_tracker_min_sel_update.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : min_sel_update                                            |
// | Brief    : Combinational best-so-far compare/select (min or max).    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module min_sel_update #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] i_best_val,
    input  logic [IDX_W-1:0] i_best_idx,
    input  logic [WIDTH-1:0] i_cand_val,
    input  logic [IDX_W-1:0] i_cand_idx,
    input  logic             i_first,
    input  logic             i_sel_max,
    output logic [WIDTH-1:0] o_new_val,
    output logic [IDX_W-1:0] o_new_idx
);

    logic w_better;
    logic w_take;

    // Strict comparison keeps the earliest occurrence on ties.
    assign w_better  = i_sel_max ? (i_cand_val > i_best_val) : (i_cand_val < i_best_val);
    assign w_take    = i_first | w_better;
    assign o_new_val = w_take ? i_cand_val : i_best_val;
    assign o_new_idx = w_take ? i_cand_idx : i_best_idx;

endmodule
`default_nettype wire

// File: rtl/stream_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stream_min_tracker                                        |
// | Brief    : Per-frame minimum/first-index/length over a valid/ready   |
// |            stream. Define STREAM_MIN_TRACKER_MAX_EN to also report   |
// |            the maximum and its first index.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stream_min_tracker
    import stream_min_tracker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
`ifdef STREAM_MIN_TRACKER_MAX_EN
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_max_idx,
`endif
    output logic             out_ovf
);

    localparam logic [IDX_W:0] c_limit = (IDX_W+1)'(frame_limit(IDX_W));

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_min;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_count;
    logic [WIDTH-1:0] r_out_min;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W:0]   r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic             w_first;
    logic [IDX_W:0]   w_count_nxt;
    logic             w_limit_hit;
    logic             w_close;
    logic [IDX_W-1:0] w_cand_idx;
    logic [WIDTH-1:0] w_min_nxt;
    logic [IDX_W-1:0] w_idx_nxt;

    assign w_accept    = in_valid & r_in_ready & (r_state == ACCUM);
    assign w_first     = (r_count == '0);
    assign w_count_nxt = r_count + 1'b1;
    assign w_limit_hit = (w_count_nxt == c_limit);
    assign w_close     = in_last | w_limit_hit;
    // Accepting a beat implies count < limit, so the low bits are the beat index.
    assign w_cand_idx  = r_count[IDX_W-1:0];

    min_sel_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_min_sel (
        .i_best_val (r_min),
        .i_best_idx (r_idx),
        .i_cand_val (in_data),
        .i_cand_idx (w_cand_idx),
        .i_first    (w_first),
        .i_sel_max  (c_sel_min),
        .o_new_val  (w_min_nxt),
        .o_new_idx  (w_idx_nxt)
    );

`ifdef STREAM_MIN_TRACKER_MAX_EN
    logic [WIDTH-1:0] r_max;
    logic [IDX_W-1:0] r_max_idx;
    logic [WIDTH-1:0] r_out_max;
    logic [IDX_W-1:0] r_out_max_idx;
    logic [WIDTH-1:0] w_max_nxt;
    logic [IDX_W-1:0] w_max_idx_nxt;

    min_sel_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_max_sel (
        .i_best_val (r_max),
        .i_best_idx (r_max_idx),
        .i_cand_val (in_data),
        .i_cand_idx (w_cand_idx),
        .i_first    (w_first),
        .i_sel_max  (c_sel_max),
        .o_new_val  (w_max_nxt),
        .o_new_idx  (w_max_idx_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max         <= '0;
            r_max_idx     <= '0;
            r_out_max     <= '0;
            r_out_max_idx <= '0;
        end else if (w_accept) begin
            r_max     <= w_max_nxt;
            r_max_idx <= w_max_idx_nxt;
            if (w_close) begin
                r_out_max     <= w_max_nxt;
                r_out_max_idx <= w_max_idx_nxt;
            end
        end
    end

    assign out_max     = r_out_max;
    assign out_max_idx = r_out_max_idx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_min       <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_out_min   <= '0;
            r_out_idx   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_min   <= w_min_nxt;
                        r_idx   <= w_idx_nxt;
                        r_count <= w_count_nxt;
                        if (w_close) begin
                            r_out_min   <= w_min_nxt;
                            r_out_idx   <= w_idx_nxt;
                            r_out_count <= w_count_nxt;
                            r_out_ovf   <= ~in_last;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_count     <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_min   = r_out_min;
    assign out_idx   = r_out_idx;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
